// File: rtl/pmci_vdm_tx_pkg.sv
// Shared definitions for the PCIe-VDM transmit packet buffer: CSR offsets,
// register bit positions and the fill/send state encoding.
package pmci_vdm_tx_pkg;

    localparam int FCR_OFS  = 'h00;
    localparam int TXDR_OFS = 'h08;
    localparam int STS_OFS  = 'h10;

    localparam int FCR_COMMIT_BIT  = 0;
    localparam int FCR_BUSY_BIT    = 31;
    localparam int STS_B2B_BIT     = 0;
    localparam int STS_OVF_BIT     = 1;
    localparam int STS_EMPTY_BIT   = 2;
    localparam int STS_DROPCLR_BIT = 31;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_SEND = 1'b1
    } tx_state_e;

endpackage

// File: rtl/pmci_vdm_tx_ram.sv
// Simple dual-port payload RAM with a registered, enabled read port.
// A read of the address being written in the same cycle returns the new word.
module pmci_vdm_tx_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pmci_vdm_tx_pkt_buf.sv
// Transmit packet buffer for the PCIe-VDM window: CSR writes fill a single-packet
// buffer, COMMIT streams it out as AXI-S, and data written while sending is dropped.
module pmci_vdm_tx_pkt_buf
    import pmci_vdm_tx_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] avmm_address,
    input  logic              avmm_write,
    input  logic [31:0]       avmm_writedata,
    input  logic              avmm_read,
    output logic [31:0]       avmm_readdata,
    output logic              avmm_readdatavalid,
    output logic              avmm_waitrequest,
    output logic              tx_tvalid,
    input  logic              tx_tready,
    output logic [31:0]       tx_tdata,
    output logic              tx_tlast,
    output logic              drop_irq
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, len_q, len_d;
    logic [CNT_W-1:0] fetch_idx_q, fetch_idx_d, ld_idx_q, ld_idx_d;
    logic             ram_vld_q, ram_vld_d;
    logic             tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [31:0]      tdata_q, tdata_d;
    logic             b2b_q, b2b_d, ovf_q, ovf_d, ec_q, ec_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    logic             wr_fcr, wr_txdr, wr_sts, commit_req;
    logic             ram_we, ram_re;
    logic [AW-1:0]    ram_waddr, ram_raddr;
    logic [31:0]      ram_rdata;
    logic             out_fire, load_b;
    logic             b2b_set, ovf_set, ec_set, drop_inc, drop_clr;
    logic [CNT_W-1:0] cnt_after;
    logic             busy;
    logic [15:0]      free_words;
    logic [31:0]      fcr_val, sts_val;

    assign wr_fcr     = avmm_write && (avmm_address == ADDR_W'(FCR_OFS));
    assign wr_txdr    = avmm_write && (avmm_address == ADDR_W'(TXDR_OFS));
    assign wr_sts     = avmm_write && (avmm_address == ADDR_W'(STS_OFS));
    assign commit_req = wr_fcr && avmm_writedata[FCR_COMMIT_BIT];
    assign drop_clr   = wr_sts && avmm_writedata[STS_DROPCLR_BIT];

    // Two-slot output pipe: RAM read register feeds the tdata register, so a
    // word is always prefetched and one beat per cycle is sustained.
    assign out_fire = tvalid_q && tx_tready;
    assign load_b   = ram_vld_q && (!tvalid_q || tx_tready);

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        len_d       = len_q;
        fetch_idx_d = fetch_idx_q;
        ld_idx_d    = ld_idx_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tdata_d     = tdata_q;
        ram_we      = 1'b0;
        ram_waddr   = wr_cnt_q[AW-1:0];
        ram_re      = 1'b0;
        ram_raddr   = fetch_idx_q[AW-1:0];
        cnt_after   = wr_cnt_q;
        b2b_set     = 1'b0;
        ovf_set     = 1'b0;
        ec_set      = 1'b0;
        drop_inc    = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (wr_txdr) begin
                    if (wr_cnt_q < DEPTH_C) begin
                        ram_we    = 1'b1;
                        cnt_after = wr_cnt_q + ONE_C;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
                wr_cnt_d = cnt_after;
                if (commit_req) begin
                    if (cnt_after != '0) begin
                        state_d     = ST_SEND;
                        len_d       = cnt_after;
                        ram_re      = 1'b1;
                        ram_raddr   = '0;
                        fetch_idx_d = ONE_C;
                        ld_idx_d    = '0;
                    end else begin
                        ec_set = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (wr_txdr) begin
                    b2b_set  = 1'b1;
                    drop_inc = 1'b1;
                end
                if ((fetch_idx_q < len_q) && (!ram_vld_q || load_b)) begin
                    ram_re      = 1'b1;
                    fetch_idx_d = fetch_idx_q + ONE_C;
                end
                if (load_b) begin
                    tvalid_d = 1'b1;
                    tdata_d  = ram_rdata;
                    tlast_d  = (ld_idx_q == (len_q - ONE_C));
                    ld_idx_d = ld_idx_q + ONE_C;
                end else if (out_fire) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                end
                if (out_fire && tlast_q) begin
                    state_d  = ST_FILL;
                    wr_cnt_d = '0;
                end
            end
            default: state_d = ST_FILL;
        endcase

        ram_vld_d = ram_re ? 1'b1 : (load_b ? 1'b0 : ram_vld_q);
    end

    // Sticky bits: a set in the same cycle as a write-1-to-clear wins.
    always_comb begin
        b2b_d = (b2b_q && !(wr_sts && avmm_writedata[STS_B2B_BIT]))   || b2b_set;
        ovf_d = (ovf_q && !(wr_sts && avmm_writedata[STS_OVF_BIT]))   || ovf_set;
        ec_d  = (ec_q  && !(wr_sts && avmm_writedata[STS_EMPTY_BIT])) || ec_set;
        drop_cnt_d = drop_cnt_q;
        if (drop_inc) begin
            drop_cnt_d = drop_clr ? 16'd1 : sat_inc16(drop_cnt_q);
        end else if (drop_clr) begin
            drop_cnt_d = '0;
        end
    end

    assign busy       = (state_q == ST_SEND);
    assign free_words = busy ? 16'd0 : 16'(DEPTH_C - wr_cnt_q);

    always_comb begin
        fcr_val               = '0;
        fcr_val[FCR_BUSY_BIT] = busy;
        fcr_val[15:0]         = free_words;
        sts_val                = '0;
        sts_val[31:16]         = drop_cnt_q;
        sts_val[STS_EMPTY_BIT] = ec_q;
        sts_val[STS_OVF_BIT]   = ovf_q;
        sts_val[STS_B2B_BIT]   = b2b_q;

        rvalid_d = avmm_read;
        rdata_d  = '0;
        if (avmm_read) begin
            if (avmm_address == ADDR_W'(FCR_OFS)) begin
                rdata_d = fcr_val;
            end else if (avmm_address == ADDR_W'(STS_OFS)) begin
                rdata_d = sts_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            wr_cnt_q    <= '0;
            len_q       <= '0;
            fetch_idx_q <= '0;
            ld_idx_q    <= '0;
            ram_vld_q   <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            b2b_q       <= 1'b0;
            ovf_q       <= 1'b0;
            ec_q        <= 1'b0;
            drop_cnt_q  <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            len_q       <= len_d;
            fetch_idx_q <= fetch_idx_d;
            ld_idx_q    <= ld_idx_d;
            ram_vld_q   <= ram_vld_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
            b2b_q       <= b2b_d;
            ovf_q       <= ovf_d;
            ec_q        <= ec_d;
            drop_cnt_q  <= drop_cnt_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
        end
    end

    pmci_vdm_tx_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (avmm_writedata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign avmm_readdata      = rdata_q;
    assign avmm_readdatavalid = rvalid_q;
    assign avmm_waitrequest   = 1'b0;
    assign tx_tvalid          = tvalid_q;
    assign tx_tdata           = tdata_q;
    assign tx_tlast           = tlast_q;
    assign drop_irq           = b2b_q || ovf_q || ec_q;

endmodule

// File: tb/tb_pmci_vdm_tx_pkt_buf.sv
// Bench for the VDM transmit packet buffer: CSR traffic and random back-pressure
// checked against a queue-based model of the buffer, packets and status.
module tb_pmci_vdm_tx_pkt_buf;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] A_FCR  = 5'h00;
    localparam logic [ADDR_W-1:0] A_TXDR = 5'h08;
    localparam logic [ADDR_W-1:0] A_STS  = 5'h10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] avmm_address;
    logic              avmm_write;
    logic [31:0]       avmm_writedata;
    logic              avmm_read;
    logic [31:0]       avmm_readdata;
    logic              avmm_readdatavalid;
    logic              avmm_waitrequest;
    logic              tx_tvalid;
    logic              tx_tready;
    logic [31:0]       tx_tdata;
    logic              tx_tlast;
    logic              drop_irq;

    always #5 clk = ~clk;

    pmci_vdm_tx_pkt_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .avmm_address       (avmm_address),
        .avmm_write         (avmm_write),
        .avmm_writedata     (avmm_writedata),
        .avmm_read          (avmm_read),
        .avmm_readdata      (avmm_readdata),
        .avmm_readdatavalid (avmm_readdatavalid),
        .avmm_waitrequest   (avmm_waitrequest),
        .tx_tvalid          (tx_tvalid),
        .tx_tready          (tx_tready),
        .tx_tdata           (tx_tdata),
        .tx_tlast           (tx_tlast),
        .drop_irq           (drop_irq)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] buf_q[$];
    logic        m_ovf, m_b2b, m_ec;
    int          m_drop;
    int          n_cmp = 0;
    int          n_err = 0;
    int          beats_seen = 0;
    int          tr_mode = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_sts();
        logic [15:0] dc;
        dc = 16'(m_drop);
        return {dc, 13'b0, m_ec, m_ovf, m_b2b};
    endfunction

    function automatic logic [31:0] exp_fcr();
        if (exp_q.size() != 0) return 32'h8000_0000;
        return 32'(DEPTH - buf_q.size());
    endfunction

    task automatic model_reset();
        exp_q.delete();
        buf_q.delete();
        m_ovf  = 1'b0;
        m_b2b  = 1'b0;
        m_ec   = 1'b0;
        m_drop = 0;
    endtask

    // Effect of one CSR write on the abstract buffer state.
    task automatic model_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        bit busy;
        int n;
        busy = (exp_q.size() != 0);
        if (a == A_TXDR) begin
            if (busy) begin
                m_b2b = 1'b1;
                if (m_drop < 65535) m_drop++;
            end else if (buf_q.size() < DEPTH) begin
                buf_q.push_back(d);
            end else begin
                m_ovf = 1'b1;
            end
        end else if (a == A_FCR) begin
            if (d[0] && !busy) begin
                n = buf_q.size();
                if (n == 0) m_ec = 1'b1;
                for (int i = 0; i < n; i++) exp_q.push_back(beat_t'{data: buf_q[i], last: (i == n - 1)});
                buf_q.delete();
            end
        end else if (a == A_STS) begin
            if (d[0])  m_b2b = 1'b0;
            if (d[1])  m_ovf = 1'b0;
            if (d[2])  m_ec  = 1'b0;
            if (d[31]) m_drop = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        case (tr_mode)
            0:       tx_tready = 1'b1;
            1:       tx_tready = !tx_tready;
            2:       tx_tready = 1'b0;
            default: tx_tready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic bus_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        model_wr(a, d);
        avmm_address   = a;
        avmm_writedata = d;
        avmm_write     = 1'b1;
        tick();
        avmm_write     = 1'b0;
    endtask

    task automatic bus_rd(input logic [ADDR_W-1:0] a, input string tag);
        logic [31:0] e;
        if (a == A_FCR)      e = exp_fcr();
        else if (a == A_STS) e = exp_sts();
        else                 e = 32'h0;
        avmm_address = a;
        avmm_read    = 1'b1;
        tick();
        avmm_read    = 1'b0;
        chk({tag, "_rdv"}, 32'(avmm_readdatavalid), 32'h1);
        chk(tag, avmm_readdata, e);
        chk({tag, "_irq"}, 32'(drop_irq), 32'(m_b2b | m_ovf | m_ec));
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'h0);
        chk("idle_tvalid", 32'(tx_tvalid), 32'h0);
        exp_q.delete();
    endtask

    // Beat monitor: samples at the falling edge, between driver updates and the next rising edge.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_tvalid", 32'(tx_tvalid), 32'h1);
                chk("hold_tdata", tx_tdata, prev_data);
                chk("hold_tlast", 32'(tx_tlast), 32'(prev_last));
            end
            if (tx_tvalid && tx_tready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", tx_tdata, 32'hDEAD_BEEF);
                end else begin
                    chk("beat_tdata", tx_tdata, exp_q[0].data);
                    chk("beat_tlast", 32'(tx_tlast), 32'(exp_q[0].last));
                    void'(exp_q.pop_front());
                end
                beats_seen <= beats_seen + 1;
            end
            prev_stall <= tx_tvalid && !tx_tready;
            prev_data  <= tx_tdata;
            prev_last  <= tx_tlast;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bs, n, len, r;
        rst_n          = 1'b0;
        avmm_address   = '0;
        avmm_write     = 1'b0;
        avmm_writedata = '0;
        avmm_read      = 1'b0;
        tx_tready      = 1'b0;
        model_reset();

        tick();
        tick();
        chk("rst_tvalid", 32'(tx_tvalid), 32'h0);
        chk("rst_tlast", 32'(tx_tlast), 32'h0);
        chk("rst_tdata", tx_tdata, 32'h0);
        chk("rst_rdv", 32'(avmm_readdatavalid), 32'h0);
        chk("rst_rdata", avmm_readdata, 32'h0);
        chk("rst_waitreq", 32'(avmm_waitrequest), 32'h0);
        chk("rst_irq", 32'(drop_irq), 32'h0);
        rst_n = 1'b1;
        tick();
        bus_rd(A_FCR, "rst_fcr");
        bus_rd(A_STS, "rst_sts");
        bus_rd(A_TXDR, "txdr_rd");
        bus_rd(5'h04, "unmapped_rd");
        chk("waitreq", 32'(avmm_waitrequest), 32'h0);

        // Four-word packet at full rate, with first-beat latency.
        tr_mode = 0;
        tick();
        for (int i = 0; i < 4; i++) bus_wr(A_TXDR, 32'hA0 + 32'(i));
        bus_rd(A_FCR, "A_fcr_free");
        bs = beats_seen;
        bus_wr(A_FCR, 32'h1);
        chk("A_lat_c1", 32'(tx_tvalid), 32'h0);
        tick();
        chk("A_lat_c2", 32'(tx_tvalid), 32'h1);
        chk("A_first", tx_tdata, 32'hA0);
        wait_idle(50);
        chk("A_beats", 32'(beats_seen - bs), 32'd4);

        // Same packet with tready toggling every cycle.
        tr_mode = 1;
        for (int i = 0; i < 4; i++) bus_wr(A_TXDR, 32'hA0 + 32'(i));
        bs = beats_seen;
        bus_wr(A_FCR, 32'h1);
        wait_idle(50);
        chk("B_beats", 32'(beats_seen - bs), 32'd4);

        // Back-to-back writes while a stalled packet is pending.
        tr_mode = 2;
        for (int i = 0; i < 8; i++) bus_wr(A_TXDR, $urandom());
        bus_wr(A_FCR, 32'h1);
        for (int i = 0; i < 3; i++) bus_wr(A_TXDR, $urandom());
        bus_wr(A_FCR, 32'h1);
        bus_rd(A_STS, "C_sts");
        chk("C_sts_val", avmm_readdata, 32'h0003_0001);
        bus_rd(A_FCR, "C_fcr_busy");
        chk("C_irq", 32'(drop_irq), 32'h1);
        tr_mode = 3;
        wait_idle(200);
        bus_wr(A_STS, 32'h8000_0007);

        // Overflow: DEPTH+2 writes keep only the first DEPTH words.
        for (int i = 0; i < DEPTH + 2; i++) bus_wr(A_TXDR, $urandom());
        bus_rd(A_FCR, "D_fcr_full");
        bus_rd(A_STS, "D_sts_ovf");
        bs = beats_seen;
        bus_wr(A_FCR, 32'h1);
        wait_idle(DEPTH * 10);
        chk("D_beats", 32'(beats_seen - bs), 32'(DEPTH));
        bus_wr(A_STS, 32'h8000_0007);

        // Empty commit, then full clear.
        tr_mode = 0;
        bus_wr(A_FCR, 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("E_no_tvalid", 32'(tx_tvalid), 32'h0);
        end
        bus_rd(A_STS, "E_sts_ec");
        bus_wr(A_STS, 32'h8000_0007);
        bus_rd(A_STS, "E_sts_clr");
        chk("E_irq", 32'(drop_irq), 32'h0);

        // Reset asserted in the middle of a six-beat packet.
        for (int i = 0; i < 6; i++) bus_wr(A_TXDR, 32'hF0 + 32'(i));
        bs = beats_seen;
        bus_wr(A_FCR, 32'h1);
        n = 0;
        while (beats_seen - bs < 2 && n < 20) begin
            tick();
            n++;
        end
        chk("F_reached_beat2", 32'(beats_seen - bs), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("F_async_tvalid", 32'(tx_tvalid), 32'h0);
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        bus_rd(A_FCR, "F_fcr");
        bus_rd(A_STS, "F_sts");

        // Random packets with random back-pressure and CSR traffic while sending.
        for (int p = 0; p < 16; p++) begin
            tr_mode = (p % 4 == 0) ? 1 : 3;
            len = (p % 5 == 0) ? $urandom_range(1, 3) : $urandom_range(1, DEPTH);
            for (int i = 0; i < len; i++) bus_wr(A_TXDR, $urandom());
            bus_wr(A_FCR, 32'h1);
            n = 0;
            while (exp_q.size() != 0 && n < DEPTH * 20) begin
                r = $urandom_range(0, 9);
                case (r)
                    0:       bus_wr(A_TXDR, $urandom());
                    1:       bus_wr(A_FCR, 32'h1);
                    2:       bus_rd(A_STS, "R_sts_send");
                    3:       bus_rd(A_FCR, "R_fcr_send");
                    default: tick();
                endcase
                n++;
            end
            wait_idle(10);
            bus_rd(A_STS, "R_sts_idle");
            bus_rd(A_FCR, "R_fcr_idle");
            if (p % 4 == 3) bus_wr(A_STS, $urandom() & 32'h8000_0007);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
